// File: rtl/regbank_pkg.sv
// Shared types for the decode-stage register bank (write port and read mux).
package regbank_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int XLEN       = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef logic [NREGS-1:0][XLEN-1:0] reg_array_t;

endpackage

// File: rtl/wb_fifo2.sv
// 2-entry write-back request FIFO: push lands at the edge, head pops when non-empty and !hold.
// in_rdy depends only on the registered count, so a full FIFO refuses even while popping.
module wb_fifo2
    import regbank_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_vld,
    output logic       in_rdy,
    input  wb_req_t    in_dat,
    input  logic       hold,
    output logic       out_vld,
    output wb_req_t    out_dat,
    output logic [1:0] count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    wb_req_t [1:0] mem_q, mem_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;

    always_comb begin
        push     = in_vld && (count_q != FULL);
        pop      = (count_q != 2'd0) && !hold;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign in_rdy  = (count_q != FULL);
    assign out_vld = (count_q != 2'd0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/regfile_write_port.sv
// Register bank write side: buffered write-back, one commit per edge one cycle after accept, x0 fixed at zero.
// wr_ready drops only when the FIFO holds two entries; hold freezes commit but not enqueue or allocation.
module regfile_write_port #(
    parameter int BITS  = 64,
    parameter int NREGS = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_rd,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [4:0]                 wr_rd,
    input  logic [BITS-1:0]            wr_data,
    input  logic                       hold,
    output logic [NREGS-1:0][BITS-1:0] regs_out,
    output logic [NREGS-1:0]           busy,
    output logic [1:0]                 fifo_count
);

    import regbank_pkg::*;

    wb_req_t                   in_req;
    wb_req_t                   head;
    logic                      head_vld;
    logic                      commit;
    logic [NREGS-1:0][BITS-1:0] regs_q, regs_d;
    logic [NREGS-1:0]          busy_q, busy_d;

    assign in_req.rd   = wr_rd;
    assign in_req.data = wr_data;

    wb_fifo2 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (wr_valid),
        .in_rdy  (wr_ready),
        .in_dat  (in_req),
        .hold    (hold),
        .out_vld (head_vld),
        .out_dat (head),
        .count   (fifo_count)
    );

    assign commit = head_vld && !hold;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (commit && head.rd != 5'd0) begin
            regs_d[head.rd] = head.data;
            busy_d[head.rd] = 1'b0;
        end
        // Set after clear: a new allocation outranks the retiring writer.
        if (alloc_valid && alloc_rd != 5'd0) begin
            busy_d[alloc_rd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign regs_out = regs_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed and random checks of regfile_write_port against a queue-based reference model.
module tb_regfile_write_port;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid;
    logic [4:0]        alloc_rd;
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_rd;
    logic [63:0]       wr_data;
    logic              hold;
    logic [31:0][63:0] regs_out;
    logic [31:0]       busy;
    logic [1:0]        fifo_count;

    regfile_write_port dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_rd       (wr_rd),
        .wr_data     (wr_data),
        .hold        (hold),
        .regs_out    (regs_out),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_regs [32];
    logic [31:0] m_busy;
    logic [68:0] m_q [$];
    bit          accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fifo_count", {62'd0, fifo_count}, 64'(m_q.size()));
        chk("wr_ready", {63'd0, wr_ready}, {63'd0, m_q.size() != 2});
        chk("busy", {32'd0, busy}, {32'd0, m_busy});
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regs_out[%0d]", i), regs_out[i], m_regs[i]);
        end
    endtask

    // One clock: model advances with the inputs present at the edge, then outputs are checked.
    task automatic step();
        bit          rdy;
        logic [68:0] h;
        rdy = (m_q.size() != 2);
        chk("wr_ready_pre", {63'd0, wr_ready}, {63'd0, rdy});
        accepted = 1'b0;
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_busy = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (m_q.size() != 0 && !hold) begin
                h = m_q.pop_front();
                if (h[68:64] != 5'd0) begin
                    m_regs[h[68:64]] = h[63:0];
                    m_busy[h[68:64]] = 1'b0;
                end
            end
            if (alloc_valid && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
            if (wr_valid && rdy) begin
                m_q.push_back({wr_rd, wr_data});
                accepted = 1'b1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
        wr_valid = 1'b0; wr_rd = '0; wr_data = '0; hold = 1'b0;
        m_busy = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        chk("reset_count", {62'd0, fifo_count}, 64'd0);
        chk("reset_ready", {63'd0, wr_ready}, 64'd1);
        chk("reset_busy", {32'd0, busy}, 64'd0);

        // First write-back: accept at edge 1, visible after edge 2.
        wr_valid = 1'b1; wr_rd = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        step();
        chk("first_count", {62'd0, fifo_count}, 64'd1);
        chk("first_no_bypass", regs_out[5], 64'd0);
        wr_valid = 1'b0;
        step();
        chk("first_commit", regs_out[5], 64'hDEAD_BEEF_0000_0001);
        chk("first_drained", {62'd0, fifo_count}, 64'd0);

        // x0 write and x0 allocation.
        wr_valid = 1'b1; wr_rd = 5'd0; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        step();
        chk("x0_accepted", {63'd0, accepted}, 64'd1);
        wr_valid = 1'b0; alloc_valid = 1'b0;
        step();
        chk("x0_reg", regs_out[0], 64'd0);
        chk("x0_busy", {63'd0, busy[0]}, 64'd0);

        // Hold fills the FIFO; third request stalls until a slot frees.
        hold = 1'b1; wr_valid = 1'b1;
        wr_rd = 5'd1; wr_data = 64'h1111; step();
        wr_rd = 5'd2; wr_data = 64'h2222; step();
        chk("hold_full_count", {62'd0, fifo_count}, 64'd2);
        chk("hold_full_ready", {63'd0, wr_ready}, 64'd0);
        wr_rd = 5'd3; wr_data = 64'h3333; step();
        chk("hold_stall", {63'd0, accepted}, 64'd0);
        hold = 1'b0;
        step();
        chk("release_no_accept", {63'd0, accepted}, 64'd0);
        chk("release_commit1", regs_out[1], 64'h1111);
        chk("release_no2", regs_out[2], 64'd0);
        step();
        chk("third_accepted", {63'd0, accepted}, 64'd1);
        chk("release_commit2", regs_out[2], 64'h2222);
        wr_valid = 1'b0;
        step();
        chk("release_commit3", regs_out[3], 64'h3333);

        // Scoreboard: set beats clear on the same register at the same edge.
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        step();
        chk("alloc7", {63'd0, busy[7]}, 64'd1);
        alloc_valid = 1'b0; wr_valid = 1'b1; wr_rd = 5'd7; wr_data = 64'h7777;
        step();
        wr_valid = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd7;
        step();
        chk("set_wins", {63'd0, busy[7]}, 64'd1);
        alloc_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'h7778;
        step();
        wr_valid = 1'b0;
        step();
        chk("clear7", {63'd0, busy[7]}, 64'd0);
        chk("reg7", regs_out[7], 64'h7778);

        // Reset with a full held FIFO discards the queued entries.
        hold = 1'b1; wr_valid = 1'b1;
        wr_rd = 5'd10; wr_data = 64'hAAAA; step();
        wr_rd = 5'd11; wr_data = 64'hBBBB; step();
        chk("prereset_count", {62'd0, fifo_count}, 64'd2);
        wr_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; hold = 1'b0;
        chk("midreset_count", {62'd0, fifo_count}, 64'd0);
        chk("midreset_ready", {63'd0, wr_ready}, 64'd1);
        chk("midreset_reg5", regs_out[5], 64'd0);
        step(); step();
        chk("discard10", regs_out[10], 64'd0);
        chk("discard11", regs_out[11], 64'd0);

        // Streaming: one commit per edge, occupancy steady at 1.
        wr_valid = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wr_rd = 5'(i); wr_data = {32'hC0DE_0000, 32'(i * 977)};
            step();
            chk("stream_count", {62'd0, fifo_count}, 64'd1);
        end
        wr_valid = 1'b0;
        step();
        for (int i = 1; i < 32; i++) begin
            chk("stream_data", regs_out[i], {32'hC0DE_0000, 32'(i * 977)});
        end

        // Random traffic; a stalled request stays unchanged until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!(wr_valid && !wr_ready)) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_rd    = 5'($urandom_range(0, 31));
                wr_data  = {$urandom, $urandom};
            end
            hold        = ($urandom_range(0, 2) == 0);
            alloc_valid = ($urandom_range(0, 1) == 1);
            alloc_rd    = 5'($urandom_range(0, 31));
            reset       = ($urandom_range(0, 63) == 0);
            step();
            if (reset) wr_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the decode-stage register bank: the storage and write path that feed the 32-way 64-bit read mux.
- Accepts write-back requests over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Commits at most one write per cycle into a 32x64 flop array, with x0 hardwired to zero.
- Keeps a per-register busy scoreboard that decode uses for hazard stalls.

Parameters:
- BITS, 64, register width; must equal the read-mux BITS.
- NREGS, 32, register count; fixed at 32 because the address is 5 bits.
- DEPTH, 2, write FIFO depth; only 2 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  decode issued an instruction that writes alloc_rd
- alloc_rd  in  5  destination register being allocated
- wr_valid  in  1  write-back request valid
- wr_ready  out  1  FIFO can accept a request
- wr_rd  in  5  write-back destination
- wr_data  in  BITS  write-back data
- hold  in  1  stall commit; FIFO is not drained this cycle
- regs_out  out  [NREGS-1:0][BITS-1:0]  full register array, wired to the read-mux din
- busy  out  NREGS  busy[i]=1: pending write to register i
- fifo_count  out  2  FIFO occupancy, 0..2

Behaviour:
- All state updates on the rising edge of clk. reset is synchronous and active-high, and it overrides every other input in that cycle.
- Reset values:
  - regs_out all zero, busy all zero, fifo_count 0.
  - wr_ready is 1 in the first cycle after reset.
- Handshake:
  - wr_ready = (fifo_count != 2), combinational from registered count. It does not depend on wr_valid or hold.
  - Transfer occurs when wr_valid && wr_ready.
  - The producer holds wr_rd and wr_data stable while valid && !ready.
- FIFO:
  - 2 entries {rd, data}, with read and write pointers plus a count.
  - Enqueue on transfer; dequeue (commit) when count != 0 && !hold.
  - Simultaneous enqueue and dequeue leaves count unchanged and the pointers both advance. Pointers wrap modulo 2.
  - At count==2, enqueue is blocked even if a dequeue occurs the same cycle (no same-cycle pass-through of ready).
- Commit:
  - The head entry is written into regs_out[rd] at the commit edge.
  - Latency: a request accepted at edge N commits at edge N+1 if hold is low; it is visible on regs_out after that edge.
  - There is no bypass from wr_data to regs_out.
- x0:
  - A request with rd=0 is accepted and dequeued normally, but the array is not written.
  - regs_out[0] is constant zero.
  - Allocating rd=0 never sets busy[0]; busy[0] is constant 0.
- Scoreboard:
  - alloc_valid with alloc_rd!=0 sets busy[alloc_rd] at the edge.
  - A commit of rd!=0 clears busy[rd] at the edge.
  - Same edge, same register: set wins (a newer writer is outstanding).
  - Same edge, different registers: both take effect.
  - Allocating an already-busy register leaves it 1. Only one outstanding writer per register is tracked; decode must stall on busy before reallocating.
- hold:
  - Freezes the FIFO head and the array.
  - Enqueue is still allowed while count<2.
  - Scoreboard sets are still allowed.
- Reset mid-operation: pending FIFO entries are discarded and not committed; all busy bits and all registers are cleared.

Decomposition:
- Shared package regbank_pkg holds:
  - REG_ADDR_W=5, NREGS=32, XLEN=64
  - typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}
  - typedef reg_array_t [NREGS-1:0][XLEN-1:0], also used by the read mux
- Natural sub-module: wb_fifo2, a 2-entry valid/ready FIFO of wb_req_t with count, hold-gated pop and synchronous reset.
- The decoder, array and scoreboard stay in the top module.

Test Plan:
- Reset, then wr_valid=1, rd=5, data=64'hDEAD_BEEF_0000_0001, hold=0 -> wr_ready=1, fifo_count=1 after edge 1; regs_out[5]=64'hDEAD_BEEF_0000_0001 after edge 2; fifo_count=0.
- Write rd=0, data=64'hFFFF_FFFF_FFFF_FFFF -> transfer accepted and dequeued; regs_out[0] stays 0; busy[0] stays 0.
- hold=1, present 3 back-to-back writes rd=1,2,3 -> after 2 edges fifo_count=2 and wr_ready=0, third request stalls. Release hold -> commits in order 1,2,3 on consecutive edges; third accepted the cycle after count drops to 1.
- alloc rd=7, then write-back rd=7 commits while alloc_valid rd=7 in the same cycle -> busy[7] remains 1. Next write-back rd=7 with no alloc -> busy[7]=0.
- hold=1, count=2, then reset=1 for one cycle -> fifo_count=0, wr_ready=1, busy=0, all regs_out zero. Queued entries never appear in regs_out.
- Continuous writes rd=1..31 with hold=0 -> one commit per cycle, fifo_count stays at 1, each regs_out[i] matches its data.
